morse_tone_player: RTL



---
 rtl/morse_tone_player.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/morse_tone_player.sv
// Morse pattern player: shifts out a latched key pattern LSB first at BIT_DIV clocks per bit,
// gating a TONE_DIV half-period square wave onto the buzzer. MORSE_REPEAT_EN adds the repeat_en input.
module morse_tone_player #(
    parameter int CODE_W   = 32,
    parameter int LEN_W    = 6,
    parameter int BIT_DIV  = 25000000,
    parameter int TONE_DIV = 25000,
    parameter int DIV_W    = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic [LEN_W-1:0]  len,
`ifdef MORSE_REPEAT_EN
    // "repeat" is a reserved word, so the repeat request is named repeat_en
    input  logic              repeat_en,
`endif
    output logic              busy,
    output logic              done,
    output logic              key_out,
    output logic              tone_out,
    output logic [LEN_W-1:0]  bit_idx
);

    localparam logic [LEN_W-1:0] CODE_W_L  = LEN_W'(CODE_W);
    localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] TONE_LAST = DIV_W'(TONE_DIV - 1);

    typedef enum logic [1:0] {IDLE, PLAY, FIN} state_t;

    state_t            state, state_n;
    logic [CODE_W-1:0] sreg, sreg_n;
    logic [LEN_W-1:0]  last_idx, last_n;
    logic [LEN_W-1:0]  eff_len;
    logic [LEN_W-1:0]  idx_n;
    logic [DIV_W-1:0]  bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0]  tone_cnt, tone_cnt_n;
    logic              phase, phase_n;
    logic              busy_n, done_n, key_n, tone_n;
`ifdef MORSE_REPEAT_EN
    logic [CODE_W-1:0] code_lat, code_lat_n;
`endif

    assign eff_len = (len > CODE_W_L) ? CODE_W_L : len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            last_idx <= '0;
            bit_cnt  <= '0;
            tone_cnt <= '0;
            phase    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            key_out  <= 1'b0;
            tone_out <= 1'b0;
            bit_idx  <= '0;
`ifdef MORSE_REPEAT_EN
            code_lat <= '0;
`endif
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            last_idx <= last_n;
            bit_cnt  <= bit_cnt_n;
            tone_cnt <= tone_cnt_n;
            phase    <= phase_n;
            busy     <= busy_n;
            done     <= done_n;
            key_out  <= key_n;
            tone_out <= tone_n;
            bit_idx  <= idx_n;
`ifdef MORSE_REPEAT_EN
            code_lat <= code_lat_n;
`endif
        end
    end

    // Every output is computed one cycle ahead here so that all of them leave a flop.
    always_comb begin
        state_n    = state;
        sreg_n     = sreg;
        last_n     = last_idx;
        bit_cnt_n  = bit_cnt;
        tone_cnt_n = tone_cnt;
        phase_n    = phase;
        busy_n     = busy;
        done_n     = 1'b0;
        key_n      = key_out;
        tone_n     = tone_out;
        idx_n      = bit_idx;
`ifdef MORSE_REPEAT_EN
        code_lat_n = code_lat;
`endif
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                key_n  = 1'b0;
                tone_n = 1'b0;
                idx_n  = '0;
                if (start) begin
                    if (len != '0) begin
                        state_n    = PLAY;
                        sreg_n     = code;
`ifdef MORSE_REPEAT_EN
                        code_lat_n = code;
`endif
                        last_n     = eff_len - 1'b1;
                        bit_cnt_n  = '0;
                        tone_cnt_n = '0;
                        phase_n    = 1'b1;
                        busy_n     = 1'b1;
                        key_n      = code[0];
                        tone_n     = code[0];
                    end else begin
                        state_n = FIN;
                        done_n  = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (bit_cnt != BIT_LAST) begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (tone_cnt == TONE_LAST) begin
                        tone_cnt_n = '0;
                        phase_n    = ~phase;
                    end else begin
                        tone_cnt_n = tone_cnt + 1'b1;
                    end
                    tone_n = key_out & phase_n;
                end else if (bit_idx != last_idx) begin
                    // Next bit: tone phase restarts high, never continuous across bits
                    sreg_n     = sreg >> 1;
                    key_n      = sreg_n[0];
                    tone_n     = sreg_n[0];
                    idx_n      = bit_idx + 1'b1;
                    bit_cnt_n  = '0;
                    tone_cnt_n = '0;
                    phase_n    = 1'b1;
                end
`ifdef MORSE_REPEAT_EN
                else if (repeat_en) begin
                    done_n     = 1'b1;
                    sreg_n     = code_lat;
                    key_n      = code_lat[0];
                    tone_n     = code_lat[0];
                    idx_n      = '0;
                    bit_cnt_n  = '0;
                    tone_cnt_n = '0;
                    phase_n    = 1'b1;
                end
`endif
                else begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    key_n   = 1'b0;
                    tone_n  = 1'b0;
                    idx_n   = '0;
                end
            end
            FIN: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                key_n   = 1'b0;
                tone_n  = 1'b0;
                idx_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
